// File: rtl/fc_pkg.sv
// Shared definitions for the FC classifier front end and layer 1.
package fc_pkg;

  localparam int unsigned FC_WORD_SIZE = 16;
  localparam int unsigned FC_VEC_SIZE  = 128;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    PAD,
    DRAIN,
    DONE
  } pack_state_t;

endpackage

// File: rtl/fc_feature_packer.sv
// Packs the serial CNN feature stream into a VEC_SIZE-word parallel vector,
// zero-padding short frames and discarding the excess of long ones.
module fc_feature_packer
  import fc_pkg::*;
#(
  parameter int unsigned WORD_SIZE = FC_WORD_SIZE,
  parameter int unsigned VEC_SIZE  = FC_VEC_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [WORD_SIZE-1:0] in_data,
  input  logic                 in_last,
  output logic                 in_ready,
  input  logic                 fc_ack,
  output logic [WORD_SIZE-1:0] x_vec [VEC_SIZE],
  output logic                 cnn_done,
  output logic                 len_err
);

  localparam int unsigned      IDX_W    = (VEC_SIZE > 1) ? $clog2(VEC_SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_SIZE - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  pack_state_t          state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 len_err_q, len_err_d;
  logic                 wr_en;
  logic [IDX_W-1:0]     wr_idx;
  logic [WORD_SIZE-1:0] wr_data;
  logic                 beat;

  // Handshake outputs decode registered state only.
  assign in_ready = (state_q == IDLE) || (state_q == FILL) || (state_q == DRAIN);
  assign cnn_done = (state_q == DONE);
  assign len_err  = len_err_q;
  assign beat     = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_err_d = len_err_q;
    wr_en     = 1'b0;
    wr_idx    = idx_q;
    wr_data   = in_data;
    unique case (state_q)
      IDLE: begin
        idx_d = '0;
        if (beat) begin
          wr_en     = 1'b1;
          wr_idx    = '0;
          len_err_d = 1'b0;
          if (VEC_SIZE == 1) begin
            state_d = in_last ? DONE : DRAIN;
            len_err_d = !in_last;
          end else begin
            idx_d   = IDX_ONE;
            // A one-word frame is as short as any other short frame.
            state_d = in_last ? PAD : FILL;
            len_err_d = in_last;
          end
        end
      end
      FILL: begin
        if (beat) begin
          wr_en = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d   = in_last ? DONE : DRAIN;
            len_err_d = !in_last;
          end else begin
            idx_d = idx_q + IDX_ONE;
            if (in_last) begin
              state_d   = PAD;
              len_err_d = 1'b1;
            end
          end
        end
      end
      PAD: begin
        wr_en   = 1'b1;
        wr_data = '0;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end
      DRAIN: begin
        if (beat && in_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (fc_ack) begin
          state_d = IDLE;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      len_err_q <= 1'b0;
      for (int unsigned i = 0; i < VEC_SIZE; i++) begin
        x_vec[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      len_err_q <= len_err_d;
      if (wr_en) begin
        x_vec[wr_idx] <= wr_data;
      end
    end
  end

endmodule
